fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Control block that drives the instruction-fetch datapath. It owns the program counter and the instruction-memory request handshake. It delivers fetched instructions, with their PC and NPC, to the decode stage. It handles decode back-pressure, branch/jump redirects and PC wrap into the instruction-memory range. It sits between the hazard/branch logic and the instruction memory, and replaces open-coded PC feedback around the fetch stage.

## Interface
- ADDR_W, 32, PC/address width
- IMEM_BYTES, 256, instruction-memory size in bytes; any PC >= IMEM_BYTES wraps to 0
- RESET_PC, 0, first fetch address after reset
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- redirect_valid  input  1  taken branch/jump this cycle
- redirect_pc  input  ADDR_W  redirect target; bits [1:0] ignored (treated as 0)
- stall  input  1  decode cannot accept; holds the output register
- imem_req  output  1  instruction-memory request
- imem_addr  output  ADDR_W  request address (= PC register)
- imem_ack  input  1  memory data valid this cycle; zero-wait (ack in the first req cycle) allowed
- imem_data  input  32  instruction word, sampled only when imem_ack=1
- if_valid  output  1  if_ir/if_pc/if_npc hold a valid instruction
- if_ir  output  32  fetched instruction
- if_pc  output  ADDR_W  address of if_ir
- if_npc  output  ADDR_W  wrapped if_pc+4

## Operation
- States: IDLE, REQ, HOLD, DROP. A one-entry holding register (hold_ir, hold_pc) backs HOLD.
- wrap(x): x >= IMEM_BYTES gives 0; otherwise x. It is applied to pc+4 and to redirect_pc.
- imem_req = (state==REQ) || (state==DROP). imem_addr = pc.
- Once imem_req is high, imem_addr stays stable until the cycle of imem_ack.
- Output slot is free when !if_valid || !stall. if_valid && !stall at an edge means the instruction was consumed, and if_valid drops unless reloaded.
- IDLE: goes to REQ unconditionally on the next edge.
- REQ, ack=1, slot free:
  - Load if_ir=imem_data, if_pc=pc, if_npc=wrap(pc+4).
  - pc <= wrap(pc+4).
  - Stay in REQ.
- REQ, ack=1, slot not free:
  - Capture the data in the holding register; pc <= wrap(pc+4).
  - Go to HOLD; imem_req is low in HOLD.
- HOLD, slot free: move the holding register into the output register; go to REQ.
- Redirect (highest priority, evaluated at each edge with redirect_valid=1):
  - if_valid <= 0; the holding register is discarded; pc <= wrap({redirect_pc[ADDR_W-1:2],2'b00}).
  - From REQ with ack=0: go to DROP. The outstanding request stays on the old address until ack; that data is discarded; then go to REQ at the new pc.
  - From REQ with ack=1, HOLD, or IDLE: go to REQ at the new pc; any fetched data is discarded.
  - From DROP: update pc only; remain in DROP until ack.
- Stall never drops or duplicates an instruction. Program order is preserved.

## Timing
- Reset values (sampled at an edge with reset=1, overrides all):
  - state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_ir=0, if_pc=0, if_npc=0.
  - Holding register = 0.
- First imem_req occurs in the 2nd cycle after reset deasserts.
- Latency: imem_ack at edge k gives if_valid=1 with the data from edge k (one register stage).
- Throughput: one instruction per cycle with imem_ack tied 1 and stall=0.
- An N-cycle memory gives one instruction per N cycles.
- Redirect takes effect at the same edge. The next valid instruction comes from the target after that target's ack, and no wrong-path instruction is ever presented.
- Reset mid-transaction abandons the outstanding request. A late imem_ack after reset is ignored unless the block is in REQ again.

## Configuration
- FETCH_SEQ_PERF_EN defined: adds outputs perf_fetch, perf_stall and perf_flush (32 bits each). Behaviour:
  - perf_fetch increments on each instruction loaded into the output register.
  - perf_stall increments on each cycle with if_valid && stall.
  - perf_flush increments on each redirect edge.
  - All three counters wrap and reset to 0.
- FETCH_SEQ_PERF_EN undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, imem_ack=1, stall=0 → imem_addr 0,4,8,…,252,0. if_pc trails imem_addr by one cycle. At if_pc=252, if_npc=0.
- imem_ack raised 3 cycles after imem_req → imem_addr held constant for 3 cycles. if_valid=0 until the cycle after ack. if_ir equals the word returned at that ack.
- imem_ack=1, stall=1 for 4 cycles at if_pc=8 → if_pc stays 8 and the block sits in HOLD with pc=16. When stall releases, if_pc goes 12 then 16, with no instruction lost or repeated.
- redirect_valid=1, redirect_pc=0x40 while the request at 0x10 is outstanding (ack=0) → state DROP. imem_addr stays 0x10 until ack; that data is never presented. Next imem_addr=0x40 and the next valid if_pc=0x40.
- redirect_pc=0x104 together with imem_ack=1 → data discarded; next imem_addr=0. A redirect to 0x43 fetches 0x40.
- reset asserted mid-HOLD → all outputs take their reset values next cycle, and the fetch restarts at RESET_PC. With FETCH_SEQ_PERF_EN defined, counters match the fetch, stall and flush counts of the prior scenarios and reset to 0.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
// Bundles the fetch-stage signals between the sequencer, the instruction
// memory and the hazard/decode logic.
//   master : the fetch sequencer (drives imem_req/imem_addr and the if_* slot)
//   slave  : the surrounding environment (memory, decode, branch logic)
// Signals:
//   redirect_valid/redirect_pc : taken branch/jump and its target
//   stall                      : decode cannot accept the if_* slot
//   imem_req/imem_addr         : instruction-memory request and address
//   imem_ack/imem_data         : memory data valid and instruction word
//   if_valid/if_ir/if_pc/if_npc: instruction presented to decode
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              stall;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_data;
  logic              if_valid;
  logic [31:0]       if_ir;
  logic [ADDR_W-1:0] if_pc;
  logic [ADDR_W-1:0] if_npc;

  modport master (
    input  redirect_valid, redirect_pc, stall, imem_ack, imem_data,
    output imem_req, imem_addr, if_valid, if_ir, if_pc, if_npc
  );

  modport slave (
    output redirect_valid, redirect_pc, stall, imem_ack, imem_data,
    input  imem_req, imem_addr, if_valid, if_ir, if_pc, if_npc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Owns the program counter and the instruction-memory request handshake and
// presents fetched instructions (with PC and next PC) to decode. Handles
// decode back-pressure through a one-entry holding register, branch/jump
// redirects (including abandoning an outstanding request) and wrapping of
// the PC into the instruction-memory range.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : fetch_sequencer_if.master (memory request/ack, decode slot,
//            stall and redirect inputs)
//   perf_fetch/perf_stall/perf_flush : 32-bit event counters, present only
//            when FETCH_SEQ_PERF_EN is defined
// Optional feature macro: FETCH_SEQ_PERF_EN
//
// state | meaning
// IDLE  | just out of reset, request starts next cycle
// REQ   | request at pc outstanding
// HOLD  | fetched word parked in holding register, decode stalled, no request
// DROP  | request on a pre-redirect address outstanding, its data is discarded
module fetch_sequencer #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       IMEM_BYTES = 256,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                clk,
  input  logic                reset,
  fetch_sequencer_if.master   bus
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0]         perf_fetch,
  output logic [31:0]         perf_stall,
  output logic [31:0]         perf_flush
`endif
);

  // Bit 0 of the encoding is the memory request, so imem_req comes straight
  // from a flop.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    HOLD = 2'b10,
    DROP = 2'b11
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       hold_ir;
  logic [ADDR_W-1:0] hold_pc;
  logic              if_valid_q;
  logic [31:0]       if_ir_q;
  logic [ADDR_W-1:0] if_pc_q;
  logic [ADDR_W-1:0] if_npc_q;

  logic              slot_free;
  logic              keep_addr;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] hold_inc;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              redirect_pc_unused;

  function automatic logic [ADDR_W-1:0] wrap(input logic [ADDR_W-1:0] x);
    return (x >= ADDR_W'(IMEM_BYTES)) ? '0 : x;
  endfunction

  assign slot_free    = !if_valid_q || !bus.stall;
  assign pc_inc       = wrap(pc + ADDR_W'(4));
  assign hold_inc     = wrap(hold_pc + ADDR_W'(4));
  assign redirect_tgt = wrap({bus.redirect_pc[ADDR_W-1:2], 2'b00});
  assign redirect_pc_unused = ^bus.redirect_pc[1:0];

  // A request still waiting for its ack keeps its address on the bus even
  // when a redirect moves pc; addr_q catches up once the ack arrives.
  assign keep_addr = state[0] && !bus.imem_ack;

  assign bus.imem_req  = state[0];
  assign bus.imem_addr = addr_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_ir     = if_ir_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_npc    = if_npc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      addr_q     <= RESET_PC;
      hold_ir    <= '0;
      hold_pc    <= '0;
      if_valid_q <= 1'b0;
      if_ir_q    <= '0;
      if_pc_q    <= '0;
      if_npc_q   <= '0;
    end else begin
      // Consumed by decode; a load below overrides this.
      if (if_valid_q && !bus.stall) begin
        if_valid_q <= 1'b0;
      end

      if (bus.redirect_valid) begin
        if_valid_q <= 1'b0;
        hold_ir    <= '0;
        hold_pc    <= '0;
        pc         <= redirect_tgt;
        if (!keep_addr) begin
          addr_q <= redirect_tgt;
        end
        state <= keep_addr ? DROP : REQ;
      end else begin
        case (state)
          IDLE: begin
            state <= REQ;
          end
          REQ: begin
            if (bus.imem_ack) begin
              pc     <= pc_inc;
              addr_q <= pc_inc;
              if (slot_free) begin
                if_valid_q <= 1'b1;
                if_ir_q    <= bus.imem_data;
                if_pc_q    <= pc;
                if_npc_q   <= pc_inc;
              end else begin
                hold_ir <= bus.imem_data;
                hold_pc <= pc;
                state   <= HOLD;
              end
            end
          end
          HOLD: begin
            if (slot_free) begin
              if_valid_q <= 1'b1;
              if_ir_q    <= hold_ir;
              if_pc_q    <= hold_pc;
              if_npc_q   <= hold_inc;
              state      <= REQ;
            end
          end
          DROP: begin
            if (bus.imem_ack) begin
              addr_q <= pc;
              state  <= REQ;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  logic load_out;

  always_comb begin
    load_out = 1'b0;
    if (!bus.redirect_valid && slot_free) begin
      load_out = ((state == REQ) && bus.imem_ack) || (state == HOLD);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch <= '0;
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (load_out) begin
        perf_fetch <= perf_fetch + 32'd1;
      end
      if (if_valid_q && bus.stall) begin
        perf_stall <= perf_stall + 32'd1;
      end
      if (bus.redirect_valid) begin
        perf_flush <= perf_flush + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
// Directed bench for fetch_sequencer. The bench plays the instruction memory:
// every accepted ack pushes the expected {pc, word, npc} onto a scoreboard,
// and every decode consumption pops and compares it.
module tb_fetch_sequencer;

  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fetch_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;
`endif

  fetch_sequencer #(
    .ADDR_W     (ADDR_W),
    .IMEM_BYTES (256),
    .RESET_PC   ('0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FETCH_SEQ_PERF_EN
    ,
    .perf_fetch (perf_fetch),
    .perf_stall (perf_stall),
    .perf_flush (perf_flush)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] npc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_pc;
  logic [31:0] drop_addr;
  bit          drop_pending;
  int          seq = 0;
  int          pops = 0;
  int          n_load_flushed = 0;
  int          n_stall = 0;
  int          n_flush = 0;

  function automatic logic [31:0] wrap(input logic [31:0] x);
    return (x >= 32'd256) ? 32'd0 : x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle. Called just after a falling edge; returns just after the
  // next falling edge.
  task automatic cyc(input bit ack, input bit st, input bit rd = 1'b0,
                     input logic [31:0] rpc = 32'd0);
    logic [31:0] data;
    exp_t        e;
    bit          req;
    data = {16'(seq), 16'(seq) ^ 16'h5A5A};
    seq++;
    bus.imem_ack       = ack;
    bus.imem_data      = data;
    bus.stall          = st;
    bus.redirect_valid = rd;
    bus.redirect_pc    = rpc;
    #1;
    req = bus.imem_req;
    chk("if_valid", 32'(bus.if_valid), 32'(sb.size() > 0));
    if (sb.size() > 0 && st) n_stall++;
    if (sb.size() > 0 && !st && !rd) begin
      e = sb.pop_front();
      pops++;
      chk("if_pc", bus.if_pc, e.pc);
      chk("if_ir", bus.if_ir, e.ir);
      chk("if_npc", bus.if_npc, e.npc);
    end
    if (req) chk("imem_addr", bus.imem_addr, drop_pending ? drop_addr : exp_pc);
    if (req && ack) begin
      if (drop_pending) begin
        drop_pending = 1'b0;
      end else if (!rd) begin
        sb.push_back('{exp_pc, data, wrap(exp_pc + 32'd4)});
        exp_pc = wrap(exp_pc + 32'd4);
      end
    end
    if (rd) begin
      n_flush++;
      if (sb.size() > 0) n_load_flushed++;
      sb.delete();
      if (req && !ack && !drop_pending) begin
        drop_pending = 1'b1;
        drop_addr    = exp_pc;
      end
      exp_pc = wrap({rpc[31:2], 2'b00});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // One reset edge with a live ack on the bus, then reset-value checks.
  task automatic do_reset();
    reset              = 1'b1;
    bus.imem_ack       = 1'b1;
    bus.imem_data      = 32'hDEADBEEF;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    @(posedge clk);
    @(negedge clk);
    sb.delete();
    exp_pc       = 32'd0;
    drop_pending = 1'b0;
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_if_ir", bus.if_ir, 32'd0);
    chk("rst_if_pc", bus.if_pc, 32'd0);
    chk("rst_if_npc", bus.if_npc, 32'd0);
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_imem_addr", bus.imem_addr, 32'd0);
`ifdef FETCH_SEQ_PERF_EN
    chk("rst_perf_fetch", perf_fetch, 32'd0);
    chk("rst_perf_stall", perf_stall, 32'd0);
    chk("rst_perf_flush", perf_flush, 32'd0);
`endif
    reset = 1'b0;
  endtask

  initial begin
    reset              = 1'b1;
    bus.imem_ack       = 1'b0;
    bus.imem_data      = 32'd0;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    exp_pc             = 32'd0;
    drop_addr          = 32'd0;
    drop_pending       = 1'b0;

    do_reset();

    // IDLE cycle: no request yet, a stray ack must be ignored.
    chk("idle_req", 32'(bus.imem_req), 32'd0);
    cyc(1, 0);
    chk("first_req", 32'(bus.imem_req), 32'd1);
    chk("first_addr", bus.imem_addr, 32'd0);

    // Full-rate fetch across the wrap: 0,4,...,252,0.
    for (int i = 0; i < 65; i++) cyc(1, 0);
    chk("throughput", 32'(pops), 32'd64);

    // Slow memory: ack three cycles after the request.
    for (int t = 0; t < 2; t++) begin
      repeat (3) cyc(0, 0);
      chk("slow_no_valid", 32'(bus.if_valid), 32'd0);
      cyc(1, 0);
      chk("slow_valid", 32'(bus.if_valid), 32'd1);
    end

    // Stall four cycles with if_pc=8: word 12 parks in HOLD, pc moves to 16.
    repeat (4) cyc(1, 1);
    chk("stall_if_pc", bus.if_pc, 32'd8);
    chk("stall_req", 32'(bus.imem_req), 32'd0);
    chk("stall_addr", bus.imem_addr, 32'd16);
    repeat (3) cyc(1, 0);

    // Redirect with ack: data discarded, target 0x104 wraps to 0.
    cyc(1, 0, 1, 32'h104);
    chk("redir_wrap_addr", bus.imem_addr, 32'd0);
    chk("redir_wrap_valid", 32'(bus.if_valid), 32'd0);
    repeat (2) cyc(1, 0);

    // Unaligned target 0x43 fetches 0x40.
    cyc(1, 0, 1, 32'h43);
    chk("redir_align_addr", bus.imem_addr, 32'h40);
    repeat (2) cyc(1, 0);

    // Move to 0x10, then redirect to 0x40 while 0x10 is outstanding.
    cyc(1, 0, 1, 32'h10);
    cyc(0, 0, 1, 32'h40);
    chk("drop_req", 32'(bus.imem_req), 32'd1);
    chk("drop_addr", bus.imem_addr, 32'h10);
    repeat (2) cyc(0, 0);
    cyc(1, 0);
    chk("post_drop_addr", bus.imem_addr, 32'h40);
    chk("post_drop_valid", 32'(bus.if_valid), 32'd0);
    repeat (3) cyc(1, 0);

    // Enter HOLD, check counters, then reset mid-HOLD.
    repeat (2) cyc(1, 1);
    chk("hold_req", 32'(bus.imem_req), 32'd0);
`ifdef FETCH_SEQ_PERF_EN
    chk("perf_fetch", perf_fetch, 32'(pops + n_load_flushed + ((sb.size() > 0) ? 1 : 0)));
    chk("perf_stall", perf_stall, 32'(n_stall));
    chk("perf_flush", perf_flush, 32'(n_flush));
`endif
    do_reset();
    chk("restart_idle_req", 32'(bus.imem_req), 32'd0);
    cyc(1, 0);
    repeat (4) cyc(1, 0);
    chk("restart_addr", bus.imem_addr, 32'd16);
    chk("final_sb", 32'(sb.size()), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
